// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, queues returned {pc, inst} pairs for
// decode, and turns branch redirects into a queue flush plus an abort pulse.
`timescale 1ns/1ps

module inst_fetch_queue #(
  parameter int              QUEUE_DEPTH = 4,
  parameter int              ADDR_W      = 32,
  parameter int              INST_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [ADDR_W-1:0]              fetch_addr_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [ADDR_W-1:0]              mem_rsp_addr_i,
  input  logic [INST_W-1:0]              mem_rsp_inst_i,
  input  logic                           br_valid_i,
  input  logic [ADDR_W-1:0]              br_target_i,
  output logic                           br_flush_o,
  output logic                           dec_valid_o,
  input  logic                           dec_ready_i,
  output logic [INST_W-1:0]              dec_inst_o,
  output logic [ADDR_W-1:0]              dec_pc_o,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count_o,
  output logic                           dbg_state_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [ADDR_W-1:0]  pc_mem   [QUEUE_DEPTH];
  logic [INST_W-1:0]  inst_mem [QUEUE_DEPTH];
  logic               not_empty;
  logic               has_room;
  logic               push;
  logic               pop;
  logic               unused_target_bits;

  // Word alignment drops the low target bits.
  assign redirect_pc        = {br_target_i[ADDR_W-1:2], 2'b00};
  assign unused_target_bits = ^br_target_i[1:0];

  assign not_empty = (count != '0);
  assign pop       = not_empty & dec_ready_i & ~br_valid_i;
  // A full queue still accepts when the head leaves in the same cycle.
  assign has_room  = (count < CNT_W'(QUEUE_DEPTH)) | pop;
  assign push      = mem_rsp_valid_i & (state == ST_RUN) & ~br_valid_i
                   & (mem_rsp_addr_i == pc) & has_room;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_RUN;
    case (state)
      ST_RUN:   if (br_valid_i) state_next = ST_FLUSH;
      ST_FLUSH: if (br_valid_i) state_next = ST_FLUSH;
      default:  state_next = ST_RUN;
    endcase
  end

  always_comb begin
    pc_next = pc;
    if (br_valid_i) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc + ADDR_W'(4);
    end
  end

  always_comb begin
    count_next = count;
    if (br_valid_i) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      pc    <= pc_next;
      count <= count_next;
      if (br_valid_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= mem_rsp_inst_i;
    end
  end

  assign fetch_addr_o = pc;
  assign br_flush_o   = (state == ST_FLUSH);
  assign dbg_state_o  = (state == ST_FLUSH);
  assign dec_valid_o  = not_empty;
  assign dec_pc_o     = not_empty ? pc_mem[rd_ptr]   : '0;
  assign dec_inst_o   = not_empty ? inst_mem[rd_ptr] : '0;
  assign q_count_o    = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: cycle vectors with hand-derived expectations plus a
// scoreboard of {pc, inst} pairs that must appear at the decode head in order.
`timescale 1ns/1ps

module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_inst;
  logic        br_valid;
  logic [31:0] br_target;
  logic        br_flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [2:0]  q_count;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic [31:0] ri;
    logic        bv;
    logic [31:0] bt;
    logic        dr;
    logic        acc;
    logic [31:0] e_fetch;
    logic [2:0]  e_count;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_queue #(
    .QUEUE_DEPTH(4), .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_addr_o    (fetch_addr),
    .mem_rsp_valid_i (rsp_valid),
    .mem_rsp_addr_i  (rsp_addr),
    .mem_rsp_inst_i  (rsp_inst),
    .br_valid_i      (br_valid),
    .br_target_i     (br_target),
    .br_flush_o      (br_flush),
    .dec_valid_o     (dec_valid),
    .dec_ready_i     (dec_ready),
    .dec_inst_o      (dec_inst),
    .dec_pc_o        (dec_pc),
    .q_count_o       (q_count),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic [31:0] ri,
                              input logic bv, input logic [31:0] bt, input logic dr,
                              input logic acc, input logic [31:0] ef, input logic [2:0] ec,
                              input logic efl);
    vec_t v;
    v.rv = rv; v.ra = ra; v.ri = ri; v.bv = bv; v.bt = bt; v.dr = dr;
    v.acc = acc; v.e_fetch = ef; v.e_count = ec; v.e_flush = efl;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_fetch"}, fetch_addr, 32'h0);
    chk({tag, "_count"}, {29'b0, q_count}, 32'h0);
    chk({tag, "_valid"}, {31'b0, dec_valid}, 32'h0);
    chk({tag, "_flush"}, {31'b0, br_flush}, 32'h0);
    chk({tag, "_dec_pc"}, dec_pc, 32'h0);
    chk({tag, "_dec_inst"}, dec_inst, 32'h0);
  endtask

  // driver: entered #1 after a rising edge, leaves #1 after the next one
  task automatic step(input vec_t v, input int idx);
    logic [63:0] exp_head;
    rsp_valid = v.rv;
    rsp_addr  = v.ra;
    rsp_inst  = v.ri;
    br_valid  = v.bv;
    br_target = v.bt;
    dec_ready = v.dr;
    if (v.acc) exp_q.push_back({v.ra, v.ri});
    @(negedge clk);
    if (dec_valid && v.dr && !v.bv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_pop[%0d]: got pc %h inst %h expected no entry", idx, dec_pc, dec_inst);
      end else begin
        exp_head = exp_q.pop_front();
        chk($sformatf("sb_pc[%0d]", idx), dec_pc, exp_head[63:32]);
        chk($sformatf("sb_inst[%0d]", idx), dec_inst, exp_head[31:0]);
      end
    end
    @(posedge clk);
    #1;
    if (v.bv) exp_q.delete();
    chk($sformatf("fetch[%0d]", idx), fetch_addr, v.e_fetch);
    chk($sformatf("count[%0d]", idx), {29'b0, q_count}, {29'b0, v.e_count});
    chk($sformatf("valid[%0d]", idx), {31'b0, dec_valid}, {31'b0, (v.e_count != 3'd0)});
    chk($sformatf("flush[%0d]", idx), {31'b0, br_flush}, {31'b0, v.e_flush});
    chk($sformatf("state[%0d]", idx), {31'b0, dbg_state}, {31'b0, v.e_flush});
    if (v.e_count == 3'd0) begin
      chk($sformatf("empty_pc[%0d]", idx), dec_pc, 32'h0);
      chk($sformatf("empty_inst[%0d]", idx), dec_inst, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b0; rsp_valid = 1'b0; rsp_addr = '0; rsp_inst = '0;
    br_valid = 1'b0; br_target = '0; dec_ready = 1'b0;

    // basic streaming, one response per cycle, decode always ready
    vecs.push_back(mk(1, 32'h0,  32'hA0, 0, 0, 1, 1, 32'h4,  3'd1, 0));
    vecs.push_back(mk(1, 32'h4,  32'hA1, 0, 0, 1, 1, 32'h8,  3'd1, 0));
    vecs.push_back(mk(1, 32'h8,  32'hA2, 0, 0, 1, 1, 32'hC,  3'd1, 0));
    vecs.push_back(mk(1, 32'hC,  32'hA3, 0, 0, 1, 1, 32'h10, 3'd1, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,  0, 0, 1, 0, 32'h10, 3'd0, 0));
    // fill to full, drop on full, then push+pop while full
    vecs.push_back(mk(1, 32'h10, 32'hB0, 0, 0, 0, 1, 32'h14, 3'd1, 0));
    vecs.push_back(mk(1, 32'h14, 32'hB1, 0, 0, 0, 1, 32'h18, 3'd2, 0));
    vecs.push_back(mk(1, 32'h18, 32'hB2, 0, 0, 0, 1, 32'h1C, 3'd3, 0));
    vecs.push_back(mk(1, 32'h1C, 32'hB3, 0, 0, 0, 1, 32'h20, 3'd4, 0));
    vecs.push_back(mk(1, 32'h20, 32'hB4, 0, 0, 0, 0, 32'h20, 3'd4, 0));
    vecs.push_back(mk(1, 32'h20, 32'hB4, 0, 0, 1, 1, 32'h24, 3'd4, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,  0, 0, 1, 0, 32'h24, 3'd3, 0));
    // redirect with 3 queued, same-cycle response and pop discarded
    vecs.push_back(mk(1, 32'h24, 32'hCC, 1, 32'h103, 1, 0, 32'h100, 3'd0, 1));
    vecs.push_back(mk(1, 32'h100, 32'hC0, 0, 0, 1, 0, 32'h100, 3'd0, 0));
    vecs.push_back(mk(1, 32'h100, 32'hC0, 0, 0, 1, 1, 32'h104, 3'd1, 0));
    vecs.push_back(mk(0, 32'h0,  32'h0,  0, 0, 1, 0, 32'h104, 3'd0, 0));
    // address mismatch is dropped
    vecs.push_back(mk(0, 32'h0,  32'h0,  1, 32'h4, 0, 0, 32'h4, 3'd0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h4,  3'd0, 0));
    vecs.push_back(mk(1, 32'h8,  32'hD0, 0, 0, 0, 0, 32'h4,  3'd0, 0));
    vecs.push_back(mk(1, 32'h4,  32'hD1, 0, 0, 0, 1, 32'h8,  3'd1, 0));
    vecs.push_back(mk(1, 32'h8,  32'hD2, 0, 0, 0, 1, 32'hC,  3'd2, 0));
    // back-to-back redirects keep FLUSH, response in FLUSH dropped
    vecs.push_back(mk(1, 32'hC,  32'hD3, 1, 32'h200, 1, 0, 32'h200, 3'd0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,  1, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFC, 3'd0, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'hE0, 0, 0, 0, 0, 32'hFFFF_FFFC, 3'd0, 0));
    // pc wrap at the top of the address space
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'hE0, 0, 0, 0, 1, 32'h0, 3'd1, 0));
    vecs.push_back(mk(1, 32'h0,  32'hE1, 0, 0, 0, 1, 32'h4,  3'd2, 0));
    vecs.push_back(mk(1, 32'h4,  32'hE2, 0, 0, 1, 1, 32'h8,  3'd2, 0));

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // asynchronous reset mid-cycle with two entries queued
    chk("pre_rst_count", {29'b0, q_count}, 32'd2);
    #2;
    rst = 1'b0;
    rsp_valid = 1'b0; br_valid = 1'b0; dec_ready = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;

    // recovery: ready while empty is ignored, then a fresh fetch from RESET_PC
    step(mk(0, 32'h0, 32'h0,  0, 0, 1, 0, 32'h0, 3'd0, 0), 100);
    step(mk(1, 32'h0, 32'hF0, 0, 0, 0, 1, 32'h4, 3'd1, 0), 101);
    step(mk(0, 32'h0, 32'h0,  0, 0, 1, 0, 32'h4, 3'd0, 0), 102);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
